// File: rtl/cwt_pkg.sv
// -----------------------------------------------------------------------------
// cwt_pkg
// Shared definitions for the register-file load controller.
//   state_t                 : controller FSM states (IDLE, LOAD, HOLD)
//   DEF_NUMBER_OF_REGISTERS : default number of register-file slots (64)
//   DEF_BITS                : default sample width (16)
// -----------------------------------------------------------------------------
package cwt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEF_NUMBER_OF_REGISTERS = 64;
    localparam int DEF_BITS                = 16;

endpackage

// File: rtl/onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
// Converts a binary register index into a one-hot write-enable vector.
// With i_enable low the output is all-zero, so at most one bit is ever set.
// Ports:
//   i_index  [IDX_W-1:0]               binary slot index
//   i_enable                           qualifies the decode
//   o_onehot [NUMBER_OF_REGISTERS-1:0] one-hot (or all-zero) result
// -----------------------------------------------------------------------------
module onehot_dec
    import cwt_pkg::*;
#(
    parameter int NUMBER_OF_REGISTERS = DEF_NUMBER_OF_REGISTERS,
    parameter int IDX_W               = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic [IDX_W-1:0]               i_index,
    input  logic                           i_enable,
    output logic [NUMBER_OF_REGISTERS-1:0] o_onehot
);

    // Compare against every slot number; an out-of-range index
    // (non power-of-two slot count) simply decodes to all-zero.
    always_comb begin
        o_onehot = '0;
        for (int k = 0; k < NUMBER_OF_REGISTERS; k++) begin
            if (i_enable && (i_index == IDX_W'(k))) begin
                o_onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file_load_ctrl.sv
// -----------------------------------------------------------------------------
// reg_file_load_ctrl
// Sequences one frame of samples into a register file, one slot per accepted
// sample, then holds the frame until downstream acknowledges it.
// Optional feature macro: REG_FILE_LOAD_CTRL_FRAME_CNT_EN adds a 16-bit
// completed-frame counter output (frame_cnt).
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, overrides everything
//   start        request to load one frame (honoured in IDLE, or in HOLD
//                together with consume_ack)
//   abort        cancel the current frame, back to IDLE
//   in_valid     sample offered
//   in_data      sample value
//   in_ready     controller accepts a sample this cycle
//   consume_ack  downstream finished reading the frame (HOLD only)
//   WrEn         registered one-hot register-file write enable
//   WrData       registered write data broadcast to every slot
//   wr_index     next slot to be written
//   busy         high in LOAD or HOLD
//   frame_done   one-cycle pulse when the whole frame is resident
//   frame_cnt    (macro only) completed frames, wraps at 0xFFFF
// -----------------------------------------------------------------------------
module reg_file_load_ctrl
    import cwt_pkg::*;
#(
    parameter int NUMBER_OF_REGISTERS = DEF_NUMBER_OF_REGISTERS,
    parameter int BITS                = DEF_BITS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic                                   in_valid,
    input  logic [BITS-1:0]                        in_data,
    output logic                                   in_ready,
    input  logic                                   consume_ack,
    output logic [NUMBER_OF_REGISTERS-1:0]         WrEn,
    output logic [BITS-1:0]                        WrData,
    output logic [$clog2(NUMBER_OF_REGISTERS)-1:0] wr_index,
    output logic                                   busy,
    output logic                                   frame_done
`ifdef REG_FILE_LOAD_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0]                            frame_cnt
`endif
);

    localparam int                IDX_W    = $clog2(NUMBER_OF_REGISTERS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUMBER_OF_REGISTERS - 1);

    state_t                         r_state;
    state_t                         w_stateNext;
    logic [IDX_W-1:0]               r_wrIndex;
    logic [IDX_W-1:0]               w_wrIndexNext;
    logic [NUMBER_OF_REGISTERS-1:0] w_onehot;
    logic [NUMBER_OF_REGISTERS-1:0] r_wrEn;
    logic [BITS-1:0]                r_wrData;
    logic                           r_donePend;
    logic                           r_frameDone;
    logic                           w_inReady;
    logic                           w_transfer;
    logic                           w_lastSlot;

    // Ready is withdrawn combinationally under abort/rst so that upstream
    // never sees a handshake that the controller then throws away.
    assign w_inReady  = (r_state == LOAD) && !abort && !rst;
    assign w_transfer = w_inReady && in_valid;
    assign w_lastSlot = (r_wrIndex == LAST_IDX);

    // Next-state and next-index logic. abort is applied last so that it
    // wins over whatever the state-specific branch decided.
    always_comb begin
        w_stateNext   = r_state;
        w_wrIndexNext = r_wrIndex;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext   = LOAD;
                    w_wrIndexNext = '0;
                end
            end
            LOAD: begin
                if (w_transfer) begin
                    if (w_lastSlot) begin
                        w_stateNext   = HOLD;
                        w_wrIndexNext = '0;
                    end else begin
                        w_wrIndexNext = r_wrIndex + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (consume_ack) begin
                    w_stateNext   = start ? LOAD : IDLE;
                    w_wrIndexNext = '0;
                end
            end
            default: begin
                w_stateNext   = IDLE;
                w_wrIndexNext = '0;
            end
        endcase
        if (abort) begin
            w_stateNext   = IDLE;
            w_wrIndexNext = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wrIndex <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_wrIndex <= w_wrIndexNext;
        end
    end

    // Decode is qualified by the transfer itself, so the registered enable
    // below is all-zero on any cycle without an accepted sample.
    onehot_dec #(
        .NUMBER_OF_REGISTERS (NUMBER_OF_REGISTERS),
        .IDX_W               (IDX_W)
    ) u_onehot_dec (
        .i_index  (r_wrIndex),
        .i_enable (w_transfer),
        .o_onehot (w_onehot)
    );

    // Write port registers plus the two-stage frame_done pipeline: the first
    // stage lines up with the final WrEn pulse, the second produces the
    // pulse one cycle later. An abort between them kills the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrEn      <= '0;
            r_wrData    <= '0;
            r_donePend  <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_wrEn      <= w_onehot;
            if (w_transfer) begin
                r_wrData <= in_data;
            end
            r_donePend  <= w_transfer && w_lastSlot;
            r_frameDone <= r_donePend && !abort;
        end
    end

`ifdef REG_FILE_LOAD_CTRL_FRAME_CNT_EN
    logic [15:0] r_frameCnt;

    // Counts on the same edge that raises frame_done, so the value seen
    // alongside the pulse already includes that frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frameCnt <= '0;
        end else if (r_donePend && !abort) begin
            r_frameCnt <= r_frameCnt + 16'd1;
        end
    end

    assign frame_cnt = r_frameCnt;
`endif

    assign in_ready   = w_inReady;
    assign WrEn       = r_wrEn;
    assign WrData     = r_wrData;
    assign wr_index   = r_wrIndex;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frameDone;

endmodule

// File: tb/tb_reg_file_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_file_load_ctrl
// Randomised scoreboard bench for reg_file_load_ctrl. The stimulus task keeps
// a frame-level model (loading/holding flags and the next slot number) and
// pushes every expected register write and frame_done pulse into queues; an
// independent monitor pops them whenever the design presents WrEn or
// frame_done. Define REG_FILE_LOAD_CTRL_FRAME_CNT_EN to also check frame_cnt.
// -----------------------------------------------------------------------------
module tb_reg_file_load_ctrl;

    localparam int NREG = 64;
    localparam int BITS = 16;
    localparam int IW   = $clog2(NREG);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic            in_valid;
    logic [BITS-1:0] in_data;
    logic            in_ready;
    logic            consume_ack;
    logic [NREG-1:0] WrEn;
    logic [BITS-1:0] WrData;
    logic [IW-1:0]   wr_index;
    logic            busy;
    logic            frame_done;
`ifdef REG_FILE_LOAD_CTRL_FRAME_CNT_EN
    logic [15:0]     frame_cnt;
`endif

    reg_file_load_ctrl #(
        .NUMBER_OF_REGISTERS (NREG),
        .BITS                (BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .consume_ack (consume_ack),
        .WrEn        (WrEn),
        .WrData      (WrData),
        .wr_index    (wr_index),
        .busy        (busy),
        .frame_done  (frame_done)
`ifdef REG_FILE_LOAD_CTRL_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Cycle number: incremented at each rising edge, read at falling edges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit monOn  = 1'b0;

    typedef struct {
        int              slot;
        int              cyc;
        logic [BITS-1:0] data;
    } wr_t;

    wr_t wrQ[$];
    int  frameQ[$];
`ifdef REG_FILE_LOAD_CTRL_FRAME_CNT_EN
    int  doneCycles[$];
`endif

    // Frame-level model of the controller.
    bit mLoad = 1'b0;
    bit mHold = 1'b0;
    int mIdx  = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

`ifdef REG_FILE_LOAD_CTRL_FRAME_CNT_EN
    function automatic int countDone();
        int n = 0;
        foreach (doneCycles[i]) if (doneCycles[i] <= cyc) n++;
        return n;
    endfunction
`endif

    // Drive one cycle of inputs, check the state-visible outputs against the
    // model, queue expected writes/pulses, then advance the model.
    task automatic applyStimulus(input bit iRst, input bit iStart, input bit iAbort,
                                 input bit iValid, input bit iAck, input logic [BITS-1:0] iData);
        bit expReady;
        bit xfer;
        @(negedge clk);
        rst         = iRst;
        start       = iStart;
        abort       = iAbort;
        in_valid    = iValid;
        consume_ack = iAck;
        in_data     = iData;
        #1;
        expReady = mLoad && !iAbort && !iRst;
        checkOutput("in_ready", 64'(in_ready), 64'(expReady));
        checkOutput("busy", 64'(busy), 64'(mLoad || mHold));
        checkOutput("wr_index", 64'(wr_index), 64'(mIdx));
`ifdef REG_FILE_LOAD_CTRL_FRAME_CNT_EN
        checkOutput("frame_cnt", 64'(frame_cnt), 64'(countDone() % 65536));
`endif
        xfer = expReady && iValid;
        if (xfer) begin
            wrQ.push_back('{slot: mIdx, cyc: cyc + 1, data: iData});
            if (mIdx == NREG - 1) begin
                frameQ.push_back(cyc + 2);
`ifdef REG_FILE_LOAD_CTRL_FRAME_CNT_EN
                doneCycles.push_back(cyc + 2);
`endif
            end
        end
        if (iRst || iAbort) begin
            for (int i = frameQ.size() - 1; i >= 0; i--) if (frameQ[i] > cyc) frameQ.delete(i);
`ifdef REG_FILE_LOAD_CTRL_FRAME_CNT_EN
            for (int i = doneCycles.size() - 1; i >= 0; i--) if (doneCycles[i] > cyc) doneCycles.delete(i);
            if (iRst) doneCycles.delete();
`endif
            mLoad = 1'b0;
            mHold = 1'b0;
            mIdx  = 0;
        end else if (mLoad) begin
            if (xfer) begin
                if (mIdx == NREG - 1) begin
                    mLoad = 1'b0;
                    mHold = 1'b1;
                    mIdx  = 0;
                end else begin
                    mIdx++;
                end
            end
        end else if (mHold) begin
            if (iAck) begin
                mHold = 1'b0;
                mLoad = iStart;
                mIdx  = 0;
            end
        end else if (iStart) begin
            mLoad = 1'b1;
            mIdx  = 0;
        end
    endtask

    // Monitor: every falling edge, match presented writes and frame_done
    // pulses against the queued expectations, and flag anything overdue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (monOn) begin
                if (wrQ.size() > 0 && wrQ[0].cyc < cyc) begin
                    e = wrQ.pop_front();
                    checkOutput("missing_write_slot", 64'(NREG), 64'(e.slot));
                end
                if (frameQ.size() > 0 && frameQ[0] < cyc) begin
                    checkOutput("missing_frame_done", 64'(0), 64'(frameQ.pop_front()));
                end
                if (WrEn !== '0) begin
                    if (wrQ.size() == 0) begin
                        checkOutput("unexpected_WrEn", 64'(WrEn), 64'(0));
                    end else begin
                        e = wrQ.pop_front();
                        checkOutput("WrEn", 64'(WrEn), 64'(1) << e.slot);
                        checkOutput("WrData", 64'(WrData), 64'(e.data));
                        checkOutput("write_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (frame_done !== 1'b0) begin
                    if (frameQ.size() == 0) begin
                        checkOutput("unexpected_frame_done", 64'(frame_done), 64'(0));
                    end else begin
                        checkOutput("frame_done_cycle", 64'(cyc), 64'(frameQ.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        in_valid    = 1'b0;
        consume_ack = 1'b0;
        in_data     = '0;
        repeat (3) @(posedge clk);
        monOn = 1'b1;

        $display("[TB] idle after reset");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, '0);
            checkOutput("idle_WrEn", 64'(WrEn), 64'(0));
            checkOutput("idle_WrData", 64'(WrData), 64'(0));
            checkOutput("idle_frame_done", 64'(frame_done), 64'(0));
        end

        $display("[TB] frame 1: back-to-back ramp");
        applyStimulus(0, 1, 0, 0, 0, '0);
        for (int k = 0; k < NREG; k++) applyStimulus(0, 0, 0, 1, 0, BITS'(k));
        for (int i = 0; i < 4; i++) applyStimulus(0, i[0], 0, 1, 0, 16'hBEEF);
        applyStimulus(0, 0, 0, 0, 1, '0);
        applyStimulus(0, 0, 0, 0, 0, '0);

        $display("[TB] frame 2: in_valid toggling, start/ack noise");
        applyStimulus(0, 1, 0, 0, 0, '0);
        for (int n = 0; n < 400 && mLoad; n++)
            applyStimulus(0, 1'($urandom), 0, n[0], 1'($urandom), 16'($urandom));
        applyStimulus(0, 0, 0, 0, 0, '0);

        $display("[TB] frame 3: start with ack in HOLD, abort after 10");
        applyStimulus(0, 1, 0, 0, 1, '0);
        for (int n = 0; n < 400 && mIdx < 10; n++)
            applyStimulus(0, 0, 0, ($urandom % 4) != 0, 0, 16'($urandom));
        applyStimulus(0, 0, 1, 1, 0, 16'($urandom));
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 16'($urandom));

        $display("[TB] frame 4: abort right after final transfer");
        applyStimulus(0, 1, 0, 0, 0, '0);
        for (int n = 0; n < 600 && mLoad; n++)
            applyStimulus(0, 0, 0, ($urandom % 3) != 0, 0, 16'($urandom));
        applyStimulus(0, 1, 1, 1, 1, '0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, '0);

        $display("[TB] frame 5: random complete frame");
        applyStimulus(0, 1, 0, 0, 0, '0);
        for (int n = 0; n < 600 && mLoad; n++)
            applyStimulus(0, 1'($urandom), 0, ($urandom % 3) != 0, 1'($urandom), 16'($urandom));
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, '0);
        applyStimulus(0, 0, 0, 0, 1, '0);
        applyStimulus(0, 0, 0, 0, 0, '0);

        $display("[TB] frame 6: reset mid-frame");
        applyStimulus(0, 1, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0, 16'($urandom));
        applyStimulus(1, 0, 1, 1, 1, 16'($urandom));
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 1, '0);

        checkOutput("writes_outstanding", 64'(wrQ.size()), 64'(0));
        checkOutput("frame_done_outstanding", 64'(frameQ.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_load_ctrl.md
REG_FILE_LOAD_CTRL -- requirements
Module: reg_file_load_ctrl

Interface
REQ-001 SHALL have parameter NUMBER_OF_REGISTERS, default 64, number of register-file slots sequenced.
REQ-002 SHALL have parameter BITS, default 16, sample width.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to load one frame.
REQ-006 SHALL have port abort  input  1  cancel current frame.
REQ-007 SHALL have port in_valid  input  1  sample offered.
REQ-008 SHALL have port in_data  input  BITS  sample value.
REQ-009 SHALL have port in_ready  output  1  controller accepts sample.
REQ-010 SHALL have port consume_ack  input  1  downstream finished reading the frame.
REQ-011 SHALL have port WrEn  output  NUMBER_OF_REGISTERS  one-hot register-file write enable.
REQ-012 SHALL have port WrData  output  BITS  data broadcast to all WrData_n inputs.
REQ-013 SHALL have port wr_index  output  $clog2(NUMBER_OF_REGISTERS)  next slot to be written.
REQ-014 SHALL have port busy  output  1  high in LOAD or HOLD.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse, frame resident in register file.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, HOLD.
REQ-017 IDLE: in_ready=0; start=1 -> LOAD, wr_index=0.
REQ-018 LOAD: in_ready=1; transfer when in_valid & in_ready; each transfer increments wr_index by 1.
REQ-019 WrEn and WrData SHALL be registered: transfer at edge N -> WrEn bit wr_index high and WrData=in_data for exactly the cycle after edge N; WrEn all-zero otherwise.
REQ-020 WrEn SHALL never have more than one bit set.
REQ-021 Transfer with wr_index=NUMBER_OF_REGISTERS-1 -> HOLD, wr_index wraps to 0, in_ready low from next cycle.
REQ-022 frame_done SHALL pulse exactly one cycle, in the cycle after the final WrEn pulse (2 cycles after final transfer).
REQ-023 HOLD: in_ready=0; consume_ack=1 -> IDLE; consume_ack=1 with start=1 same cycle -> LOAD directly (back-to-back frames).
REQ-024 start SHALL be ignored in LOAD and in HOLD without consume_ack; consume_ack ignored outside HOLD.
REQ-025 in_valid low in LOAD SHALL stall with no WrEn and no index change; no timeout.
REQ-026 abort SHALL have priority over all inputs in any state: -> IDLE, wr_index=0, no transfer that cycle, WrEn all-zero next cycle, pending frame_done cancelled.

Reset
REQ-027 rst SHALL override abort and all other inputs.
REQ-028 On rst: state IDLE, wr_index=0, WrEn=0, WrData=0, in_ready=0, busy=0, frame_done=0.
REQ-029 rst mid-LOAD SHALL discard the partial frame; register-file contents are not cleared by this block.

Configuration
REQ-030 Macro REG_FILE_LOAD_CTRL_FRAME_CNT_EN defined: SHALL add output frame_cnt (16 bits), reset 0, incremented on each frame_done, wrapping 0xFFFF->0.
REQ-031 Macro undefined: frame_cnt port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-032 Shared package cwt_pkg SHALL hold the FSM state enum (IDLE, LOAD, HOLD) and default constants NUMBER_OF_REGISTERS=64, BITS=16.
REQ-033 Index-to-one-hot conversion SHALL be sub-module onehot_dec (index in, NUMBER_OF_REGISTERS-bit one-hot out, enable input); all else in the top module.

Verification
REQ-034 rst 3 cycles, then idle 5 cycles -> all outputs 0, WrEn=0 every cycle.
REQ-035 start, then 64 back-to-back samples 0x0000..0x003F -> WrEn[k] pulses once with WrData=k, k=0..63, frame_done once 2 cycles after last transfer, in_ready=0 afterwards.
REQ-036 LOAD with in_valid toggled every other cycle -> exactly 64 WrEn pulses, in order, no duplicates; wr_index holds during gaps.
REQ-037 abort after 10 transfers -> state IDLE, wr_index=0, no further WrEn, no frame_done; next start writes slot 0 first.
REQ-038 HOLD with start and consume_ack asserted same cycle -> LOAD next cycle, in_ready=1, first sample written to WrEn[0].
REQ-039 With REG_FILE_LOAD_CTRL_FRAME_CNT_EN: 3 complete frames -> frame_cnt=3; rst mid-frame 4 -> frame_cnt=0.
